decode38_scan_ctrl: RTL and testbench
=====================================

# decode38_scan_ctrl

Sequencing controller for the 3-to-8 decoder LED lab. It produces the 3-bit select index that drives the decoder's a2..a0 inputs, so the eight LEDs show a manual position, an up or down chase, or a ping-pong sweep. The sweep is paced by an internal prescaler or single-stepped from a debounced pushbutton. It sits between the board switches and buttons and the decoder instance in the top level.

## Interface
- CNT_MAX, 12_499_999, prescaler terminal count; auto-advance period is CNT_MAX+1 clocks (4 Hz at 50 MHz)
- CNT_W, 24, prescaler counter width; must hold CNT_MAX
- DEB_CYC, 500_000, consecutive stable cycles required to accept a Step_In level change (10 ms at 50 MHz)
- DEB_W, 20, debounce counter width; must hold DEB_CYC

Ports:
- Clk_In  in  1  system clock; the block has one clock
- Rst_In  in  1  reset, asynchronous, active-high
- Mode_In  in  2  00 manual, 01 up, 10 down, 11 ping-pong
- Sw_In  in  3  manual index, used in mode 00
- Run_In  in  1  1 = auto-advance on prescaler tick, 0 = paused (step only)
- Step_In  in  1  raw pushbutton, active-high, asynchronous to Clk_In
- Sel_Out  out  3  index to decoder a2..a0
- Dir_Out  out  1  current direction, 1 = up
- Tick_Out  out  1  one-cycle pulse, high in the first cycle Sel_Out shows an advanced value
- Wrap_Out  out  1  one-cycle pulse, coincident with Tick_Out, on a wrap (7->0 or 0->7) or a ping-pong turnaround

## Operation
- Reset values: Sel_Out=0, Dir_Out=1, Tick_Out=0, Wrap_Out=0. Prescaler, debounce counter, synchronizer and debounced level all reset to 0.
- Step path:
  - Step_In passes through a 2-FF synchronizer.
  - The debounced level changes only after the synchronized value differs from it for DEB_CYC consecutive cycles. Any bounce restarts the count.
  - A 0->1 change of the debounced level is a step event.
- Prescaler:
  - Counts 0..CNT_MAX only while Run_In=1 and Mode_In!=00.
  - tick = (count==CNT_MAX); the count then returns to 0.
  - Otherwise the count is held at 0.
- Advance event = tick when Run_In=1, or step event when Run_In=0. Mode 00 never advances. Step events are ignored while Run_In=1.
- Mode 00: Sel_Out <= Sw_In every cycle. Dir_Out is held. Tick_Out and Wrap_Out stay 0.
- Mode 01 (up): Dir_Out=1. On advance, Sel_Out <= Sel_Out+1 mod 8. 7->0 asserts Wrap_Out.
- Mode 10 (down): Dir_Out=0. On advance, Sel_Out <= Sel_Out-1 mod 8. 0->7 asserts Wrap_Out.
- Mode 11 (ping-pong) keeps the current Dir_Out:
  - Up and Sel_Out<7: increment.
  - Up and Sel_Out==7: Sel_Out <= 6, Dir_Out <= 0, Wrap_Out.
  - Down and Sel_Out>0: decrement.
  - Down and Sel_Out==0: Sel_Out <= 1, Dir_Out <= 1, Wrap_Out.
- Mode changes:
  - Sel_Out continues from its current value; no jump.
  - Dir_Out is forced on the first cycle of mode 01/10.
  - A mode change in the same cycle as an advance: the new mode governs that advance.

## Timing
- Tick to new Sel_Out is one clock. Tick_Out and Wrap_Out are registered and aligned with the new Sel_Out.
- Manual latency: Sw_In to Sel_Out is one clock.
- Step latency: 2 (sync) + DEB_CYC + 1 clocks from a clean Step_In rise to the new Sel_Out.
- Run_In falling mid-count: the prescaler clears on the next edge and no tick is issued. Run_In rising: the first tick arrives CNT_MAX+1 clocks later.
- Rst_In asserted mid-sweep forces all outputs to their reset values immediately (asynchronously). The first post-reset tick comes CNT_MAX+1 clocks after reset release, with Run_In=1.
- Pulse outputs never stay high longer than one cycle. Back-to-back advances are impossible when CNT_MAX>=1.

## Test plan
All scenarios use CNT_MAX=3, DEB_CYC=2.
- Reset, then mode 01 with Run_In=1 -> Sel_Out steps 0,1,...,7,0, once every 4 clocks. Tick_Out pulses each step. Wrap_Out pulses only on 7->0.
- Mode 11 with Run_In=1 from Sel_Out=5 -> sequence 6,7,6,5,...,0,1. Dir_Out goes to 0 at 7->6 and back to 1 at 0->1. Wrap_Out pulses at both turnarounds.
- Mode 10 with Run_In=0. Step_In bounces 1,0,1, then holds 1 for 5 cycles -> exactly one decrement, 0->7, with Wrap_Out=1. Step_In held high afterwards gives no further steps.
- Mode 00 with Sw_In=3'b101 -> Sel_Out=5 one clock later. Switching to mode 01 -> the next tick gives 6 and Dir_Out=1.
- Rst_In pulsed while Sel_Out=4 in mode 01 -> Sel_Out=0 and Dir_Out=1 without waiting for a clock edge. The first tick comes 4 clocks after release.
- Run_In dropped at prescaler count 2 -> no Tick_Out. Run_In reasserted -> the next advance comes exactly 4 clocks later.

Source files
------------

// File: rtl/decode38_scan_ctrl_if.sv
// Switch/button inputs and decoder-side outputs of the 3-to-8 scan controller.
interface decode38_scan_ctrl_if;
    logic [1:0] Mode_In;
    logic [2:0] Sw_In;
    logic       Run_In;
    logic       Step_In;
    logic [2:0] Sel_Out;
    logic       Dir_Out;
    logic       Tick_Out;
    logic       Wrap_Out;

    modport master (
        output Mode_In, Sw_In, Run_In, Step_In,
        input  Sel_Out, Dir_Out, Tick_Out, Wrap_Out
    );

    modport slave (
        input  Mode_In, Sw_In, Run_In, Step_In,
        output Sel_Out, Dir_Out, Tick_Out, Wrap_Out
    );
endinterface

// File: rtl/decode38_scan_ctrl.sv
// Select-index sequencer for the 3-to-8 decoder LED lab: manual, up, down,
// ping-pong, paced by a prescaler or a debounced step button.
module decode38_scan_ctrl #(
    parameter int CNT_MAX = 12_499_999,
    parameter int CNT_W   = 24,
    parameter int DEB_CYC = 500_000,
    parameter int DEB_W   = 20
) (
    input  logic                  Clk_In,
    input  logic                  Rst_In,
    decode38_scan_ctrl_if.slave   bus_io
);
    localparam logic [CNT_W-1:0] CntTop = CNT_W'(CNT_MAX);
    localparam logic [DEB_W-1:0] DebTop = DEB_W'(DEB_CYC - 1);

    logic [1:0]       sync_q;
    logic             deb_q, deb_d;
    logic             deb_prev_q;
    logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic             dir_q, dir_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    logic run_en, tick, step_evt, adv;

    // Level only flips after DEB_CYC straight cycles of disagreement.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync_q[1] != deb_q) begin
            if (deb_cnt_q == DebTop) begin
                deb_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + DEB_W'(1);
            end
        end
    end

    assign step_evt = deb_q & ~deb_prev_q;
    assign run_en   = bus_io.Run_In && (bus_io.Mode_In != 2'b00);
    assign tick     = run_en && (cnt_q == CntTop);
    assign cnt_d    = (!run_en || tick) ? '0 : cnt_q + CNT_W'(1);
    assign adv      = (bus_io.Mode_In != 2'b00) &&
                      (bus_io.Run_In ? tick : step_evt);

    always_comb begin
        sel_d  = sel_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        unique case (bus_io.Mode_In)
            2'b00: sel_d = bus_io.Sw_In;
            2'b01: begin
                dir_d = 1'b1;
                if (adv) begin
                    sel_d  = sel_q + 3'd1;
                    tick_d = 1'b1;
                    wrap_d = (sel_q == 3'd7);
                end
            end
            2'b10: begin
                dir_d = 1'b0;
                if (adv) begin
                    sel_d  = sel_q - 3'd1;
                    tick_d = 1'b1;
                    wrap_d = (sel_q == 3'd0);
                end
            end
            2'b11: begin
                if (adv) begin
                    tick_d = 1'b1;
                    if (dir_q) begin
                        if (sel_q == 3'd7) begin
                            sel_d  = 3'd6;
                            dir_d  = 1'b0;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q + 3'd1;
                        end
                    end else begin
                        if (sel_q == 3'd0) begin
                            sel_d  = 3'd1;
                            dir_d  = 1'b1;
                            wrap_d = 1'b1;
                        end else begin
                            sel_d = sel_q - 3'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk_In or posedge Rst_In) begin
        if (Rst_In) begin
            sync_q     <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            cnt_q      <= '0;
            sel_q      <= '0;
            dir_q      <= 1'b1;
            tick_q     <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], bus_io.Step_In};
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            dir_q      <= dir_d;
            tick_q     <= tick_d;
            wrap_q     <= wrap_d;
        end
    end

    assign bus_io.Sel_Out  = sel_q;
    assign bus_io.Dir_Out  = dir_q;
    assign bus_io.Tick_Out = tick_q;
    assign bus_io.Wrap_Out = wrap_q;
endmodule

// File: tb/tb_decode38_scan_ctrl.sv
// Scoreboard bench for decode38_scan_ctrl with CNT_MAX=3, DEB_CYC=2.
module tb_decode38_scan_ctrl;
    logic clk;
    logic rst;
    int   cyc;
    int   total;
    int   bad;

    typedef struct {
        int cyc;
        int sel;
        int dir;
        int wrap;
    } exp_t;

    exp_t q[$];

    decode38_scan_ctrl_if bus ();

    decode38_scan_ctrl #(
        .CNT_MAX(3),
        .CNT_W  (4),
        .DEB_CYC(2),
        .DEB_W  (4)
    ) dut (
        .Clk_In(clk),
        .Rst_In(rst),
        .bus_io(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, want, $time);
        end
    endtask

    task automatic push(input int c, input int s, input int d, input int w);
        exp_t e;
        e.cyc  = c;
        e.sel  = s;
        e.dir  = d;
        e.wrap = w;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every Tick_Out must match the next queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.Tick_Out) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_tick got sel=%0d want none cyc=%0d",
                             bus.Sel_Out, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("tick_cyc", cyc, e.cyc);
                    chk("tick_sel", int'(bus.Sel_Out), e.sel);
                    chk("tick_dir", int'(bus.Dir_Out), e.dir);
                    chk("tick_wrap", int'(bus.Wrap_Out), e.wrap);
                end
            end else begin
                chk("wrap_idle", int'(bus.Wrap_Out), 0);
            end
        end
    end

    int n;
    int pp_sel[10] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int pp_dir[10] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1};
    int pp_wrp[10] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.Mode_In = 2'b00;
        bus.Sw_In   = 3'b110;
        bus.Run_In  = 1'b0;
        bus.Step_In = 1'b0;
        #2 rst = 1'b1;

        @(negedge clk);
        chk("rst_sel", int'(bus.Sel_Out), 0);
        chk("rst_dir", int'(bus.Dir_Out), 1);
        chk("rst_tick", int'(bus.Tick_Out), 0);
        chk("rst_wrap", int'(bus.Wrap_Out), 0);

        // Up count 0..7,0 every 4 clocks from reset release
        @(posedge clk);
        #1;
        n = cyc;
        rst = 1'b0;
        bus.Mode_In = 2'b01;
        bus.Run_In  = 1'b1;
        for (int k = 1; k <= 8; k++) push(n + 4 * k, k % 8, 1, k == 8 ? 1 : 0);
        wait_cyc(32);

        // Manual load, then up continues from 5
        bus.Mode_In = 2'b00;
        bus.Sw_In   = 3'b101;
        wait_cyc(1);
        @(negedge clk);
        chk("man_sel", int'(bus.Sel_Out), 5);
        chk("man_dir", int'(bus.Dir_Out), 1);
        @(posedge clk);
        #1;
        n = cyc;
        bus.Mode_In = 2'b01;
        push(n + 4, 6, 1, 0);
        wait_cyc(4);

        // Ping-pong from 5
        bus.Mode_In = 2'b00;
        bus.Sw_In   = 3'b101;
        wait_cyc(1);
        n = cyc;
        bus.Mode_In = 2'b11;
        for (int k = 0; k < 10; k++)
            push(n + 4 * (k + 1), pp_sel[k], pp_dir[k], pp_wrp[k]);
        wait_cyc(40);

        // Run dropped at count 2, then reasserted
        bus.Mode_In = 2'b01;
        wait_cyc(2);
        bus.Run_In = 1'b0;
        wait_cyc(3);
        n = cyc;
        bus.Run_In = 1'b1;
        push(n + 4, 2, 1, 0);
        wait_cyc(4);

        // Bouncy step in down mode from 0
        bus.Mode_In = 2'b00;
        bus.Sw_In   = 3'b000;
        bus.Run_In  = 1'b0;
        wait_cyc(1);
        n = cyc;
        bus.Mode_In = 2'b10;
        bus.Step_In = 1'b1;
        wait_cyc(1);
        bus.Step_In = 1'b0;
        wait_cyc(1);
        bus.Step_In = 1'b1;
        push(n + 7, 7, 0, 1);
        wait_cyc(15);
        bus.Step_In = 1'b0;
        wait_cyc(8);
        @(negedge clk);
        chk("step_hold_sel", int'(bus.Sel_Out), 7);
        @(posedge clk);
        #1;

        // Async reset mid-sweep at Sel=4
        bus.Mode_In = 2'b00;
        bus.Sw_In   = 3'b011;
        bus.Run_In  = 1'b1;
        wait_cyc(1);
        n = cyc;
        bus.Mode_In = 2'b01;
        push(n + 4, 4, 1, 0);
        wait_cyc(6);
        chk("pre_rst_sel", int'(bus.Sel_Out), 4);
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", int'(bus.Sel_Out), 0);
        chk("arst_dir", int'(bus.Dir_Out), 1);
        chk("arst_tick", int'(bus.Tick_Out), 0);
        @(posedge clk);
        #1;
        n = cyc;
        rst = 1'b0;
        push(n + 4, 1, 1, 0);
        wait_cyc(6);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
